// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) arbitrated controller.
// Holds the controller FSM state type, the operation encodings, the codec
// widths and the pure encode/syndrome functions used by the codec.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;
    localparam int SYN_W  = 3;

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    // Codeword bit k holds Hamming position k+1: p1 p2 d1 p4 d2 d3 d4.
    function automatic logic [CODE_W-1:0] ham74_encode(input logic [DATA_W-1:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Returns {s4,s2,s1}; a non-zero value is the position of the flipped bit.
    function automatic logic [SYN_W-1:0] ham74_syndrome(input logic [CODE_W-1:0] c);
        logic s1, s2, s4;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/hamming74_codec.sv
// Combinational Hamming(7,4) codec.
// Ports:
//   op_i   : OP_ENC or OP_DEC
//   code_i : encode uses [3:0] as data; decode uses all 7 bits as codeword
//   data_o : codeword (encode) or {3'b000, corrected data} (decode)
//   syn_o  : decode syndrome {s4,s2,s1}; zero for encode
module hamming74_codec
    import hamming_pkg::*;
(
    input  logic              op_i,
    input  logic [CODE_W-1:0] code_i,
    output logic [CODE_W-1:0] data_o,
    output logic [SYN_W-1:0]  syn_o
);

    logic [SYN_W-1:0]  syn;
    logic [CODE_W-1:0] flip;
    logic [CODE_W-1:0] fixed;

    always_comb begin
        syn   = ham74_syndrome(code_i);
        // Syndrome s names position s, which lives at codeword bit s-1.
        flip  = (syn == '0) ? '0 : (CODE_W'(1) << (syn - 3'd1));
        fixed = code_i ^ flip;
        if (op_i == OP_DEC) begin
            data_o = {3'b000, fixed[6], fixed[5], fixed[4], fixed[2]};
            syn_o  = syn;
        end else begin
            data_o = ham74_encode(code_i[DATA_W-1:0]);
            syn_o  = '0;
        end
    end

endmodule

// File: rtl/hamming_arb_ctrl.sv
// Two-requester round-robin front end for a shared Hamming(7,4) codec.
// Each accepted request goes IDLE -> EXEC -> RESP and is returned on a
// valid/ready response port; decodes that needed correction bump a
// saturating error counter.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   req_valid/op/data    : per-requester request (data 7 bits per requester)
//   req_ready            : one-hot accept strobe, IDLE only
//   rsp_valid/ready      : response handshake
//   rsp_id/data/syn      : owning requester, codec result, decode syndrome
//   err_count, clr_count : corrected-error counter and its synchronous clear
module hamming_arb_ctrl
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_op,
    input  logic [13:0]      req_data,
    output logic [1:0]       req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [6:0]       rsp_data,
    output logic [2:0]       rsp_syn,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count
);

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;        // requester that wins when both are valid
    logic   grant;
    logic   accept;

    logic              op_q;
    logic [CODE_W-1:0] arg_q;
    logic              id_q;

    logic              rsp_id_q;
    logic [CODE_W-1:0] rsp_data_q;
    logic [SYN_W-1:0]  rsp_syn_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [CODE_W-1:0] cod_data;
    logic [SYN_W-1:0]  cod_syn;

    hamming74_codec u_codec (
        .op_i   (op_q),
        .code_i (arg_q),
        .data_o (cod_data),
        .syn_o  (cod_syn)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_ready = '0;
        grant     = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid != '0) begin
                    accept           = 1'b1;
                    grant            = (req_valid == 2'b11) ? ptr_q : req_valid[1];
                    req_ready[grant] = 1'b1;
                    ptr_d            = ~grant;
                    state_d          = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_EXEC && op_q == OP_DEC && cod_syn != '0 && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
        if (clr_count)
            cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_ENC;
            arg_q      <= '0;
            id_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_syn_q  <= '0;
        end else begin
            if (accept) begin
                op_q  <= req_op[grant];
                arg_q <= grant ? req_data[13:7] : req_data[6:0];
                id_q  <= grant;
            end
            if (state_q == ST_EXEC) begin
                rsp_id_q   <= id_q;
                rsp_data_q <= cod_data;
                rsp_syn_q  <= cod_syn;
            end
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_syn   = rsp_syn_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_hamming_arb_ctrl.sv
// Scoreboard bench for hamming_arb_ctrl: stimulus pushes expected responses
// computed by a nearest-codeword reference model; a negedge monitor checks
// arbitration, latency, response contents and the error counter.
module tb_hamming_arb_ctrl;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_op;
    logic [13:0]      req_data;
    logic [1:0]       req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [6:0]       rsp_data;
    logic [2:0]       rsp_syn;
    logic [CNT_W-1:0] err_count;
    logic             clr_count;

    always #5 clk = ~clk;

    hamming_arb_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_syn   (rsp_syn),
        .err_count (err_count),
        .clr_count (clr_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic       id;
        logic       op;
        logic [6:0] data;
        logic [2:0] syn;
        int         acc;
    } exp_t;

    exp_t sbq[$];
    int   grants[$];
    bit   m_idle    = 1'b1;
    bit   m_ptr     = 1'b0;
    int   exp_cnt   = 0;
    bit   exec_pend = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endfunction

    // Reference encode straight from the parity equations.
    function automatic logic [6:0] m_encode(input logic [3:0] d);
        logic [6:0] c;
        c    = '0;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    // Reference decode: the perfect code puts every word within distance 1
    // of exactly one codeword; the syndrome is the position that differs.
    task automatic m_decode(input logic [6:0] c, output logic [6:0] data, output logic [2:0] syn);
        logic [6:0] diff;
        data = '0;
        syn  = '0;
        for (int v = 0; v < 16; v++) begin
            diff = m_encode(4'(v)) ^ c;
            if ($countones(diff) <= 1) begin
                data = {3'b000, 4'(v)};
                for (int k = 0; k < 7; k++)
                    if (diff[k]) syn = 3'(k + 1);
            end
        end
    endtask

    function automatic logic [6:0] rand_cw(input bit corrupt);
        logic [6:0] c;
        c = m_encode(4'($urandom));
        if (corrupt) c = c ^ (7'd1 << $urandom_range(0, 6));
        return c;
    endfunction

    // Monitor / scoreboard
    int         nxt;
    int         g;
    logic [1:0] exp_rr;
    bit         exp_v;
    exp_t       e;
    logic [6:0] sl;

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            chk("err_count", err_count, exp_cnt);

            nxt = exp_cnt;
            if (exec_pend && sbq.size() != 0 && sbq[0].op == 1'b1 && sbq[0].syn != 3'd0 && exp_cnt < CNT_MAX)
                nxt = exp_cnt + 1;
            if (clr_count) nxt = 0;
            exec_pend = 1'b0;

            exp_rr = '0;
            g      = 0;
            if (m_idle && req_valid != 2'b00) begin
                g = (req_valid == 2'b11) ? int'(m_ptr) : int'(req_valid[1]);
                exp_rr[g] = 1'b1;
            end
            chk("req_ready", req_ready, exp_rr);
            if (exp_rr != 2'b00) begin
                sl     = req_data[7*g +: 7];
                e.id   = g[0];
                e.op   = req_op[g];
                e.acc  = cyc;
                if (e.op == 1'b0) begin
                    e.data = m_encode(sl[3:0]);
                    e.syn  = '0;
                end else begin
                    m_decode(sl, e.data, e.syn);
                end
                sbq.push_back(e);
                grants.push_back(g);
                m_idle    = 1'b0;
                m_ptr     = ~g[0];
                exec_pend = 1'b1;
            end

            exp_v = (sbq.size() != 0) && (cyc >= sbq[0].acc + 2);
            chk("rsp_valid", rsp_valid, exp_v);
            if (rsp_valid && sbq.size() != 0) begin
                chk("rsp_id",   rsp_id,   sbq[0].id);
                chk("rsp_data", rsp_data, sbq[0].data);
                chk("rsp_syn",  rsp_syn,  sbq[0].syn);
                if (rsp_ready) begin
                    void'(sbq.pop_front());
                    m_idle = 1'b1;
                end
            end

            exp_cnt = nxt;
        end
    end

    task automatic clear_model();
        sbq.delete();
        grants.delete();
        m_idle    = 1'b1;
        m_ptr     = 1'b0;
        exp_cnt   = 0;
        exec_pend = 1'b0;
    endtask

    task automatic do_reset(input bit check_outputs);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        if (check_outputs) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data",  rsp_data,  0);
            chk("rst_rsp_syn",   rsp_syn,   0);
            chk("rst_rsp_id",    rsp_id,    0);
            chk("rst_req_ready", req_ready, 0);
        end
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic issue(input int id, input logic op, input logic [6:0] d, input bit clr_in_exec);
        bit ok;
        @(posedge clk); #1;
        req_valid[id]          = 1'b1;
        req_op[id]             = op;
        req_data[7*id +: 7]    = d;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("accept_wait");
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        if (clr_in_exec) begin
            clr_count = 1'b1;
            @(posedge clk); #1;
            clr_count = 1'b0;
        end
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("rsp_wait");
    endtask

    task automatic directed(input int id, input logic op, input logic [6:0] d,
                            input logic [6:0] want_data, input logic [2:0] want_syn);
        issue(id, op, d, 1'b0);
        wait_rsp();
        chk("dir_rsp_data", rsp_data, want_data);
        chk("dir_rsp_syn",  rsp_syn,  want_syn);
        chk("dir_rsp_id",   rsp_id,   id);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        clr_count = 1'b0;
        #1;
        chk("init_rsp_valid", rsp_valid, 0);
        chk("init_rsp_data",  rsp_data,  0);
        chk("init_rsp_syn",   rsp_syn,   0);
        chk("init_rsp_id",    rsp_id,    0);
        chk("init_err_count", err_count, 0);
        chk("init_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed codec cases
        directed(0, 1'b0, 7'h0B, 7'h55, 3'd0);
        directed(1, 1'b1, 7'h55, 7'h0B, 3'd0);
        chk("clean_dec_count", err_count, 0);
        directed(1, 1'b1, 7'h45, 7'h0B, 3'd5);
        chk("corr_dec_count", err_count, 1);

        // Clear coinciding with an increment wins
        issue(0, 1'b1, 7'h45, 1'b1);
        wait_rsp();
        chk("clr_vs_inc", err_count, 0);

        // Saturation
        for (int i = 0; i < 260; i++)
            issue(int'($urandom_range(0, 1)), 1'b1, rand_cw(1'b1), 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sat_count", err_count, CNT_MAX);

        // Backpressure: response held, nothing accepted meanwhile
        @(posedge clk); #1 rsp_ready = 1'b0;
        issue(1, 1'b1, rand_cw(1'b0), 1'b0);
        wait_rsp();
        @(posedge clk); #1 req_valid = 2'b11;
        repeat (5) @(posedge clk);
        #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Reset while a response is pending
        #1 rsp_ready = 1'b0;
        issue(0, 1'b0, 7'h03, 1'b0);
        wait_rsp();
        do_reset(1'b1);
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_rst_count", err_count, 0);

        // Round-robin with both requesters held valid from reset
        do_reset(1'b0);
        req_op    = 2'b00;
        req_data  = 14'($urandom);
        req_valid = 2'b11;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (grants.size() >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("arb_wait");
        else
            for (int i = 0; i < 4; i++) chk("arb_order", grants[i], i % 2);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            req_valid = 2'($urandom);
            req_op    = 2'($urandom);
            req_data  = {rand_cw(($urandom % 3) != 0), rand_cw(($urandom % 3) != 0)};
            rsp_ready = ($urandom % 4) != 0;
            clr_count = ($urandom % 40) == 0;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        clr_count = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
